logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit; successor to the fixed 4/8-bit combinational gate modules.
- Operates on full WIDTH-bit vectors under a 3-bit opcode, not single bits.
- Two register stages, with valid/ready handshakes on both input and output, so it can sit between streaming datapath blocks with backpressure.
- Keeps a wrap-around count of delivered results.

---
 rtl/logic_unit_pipe.sv | 111 +++++++++++
 tb/tb_logic_unit_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit (AND/OR/XOR/NOT/NAND/NOR/XNOR/PASS-B); latency 2, valid/ready both sides, holds under stall.
// Optional result flags (zero/ones/parity) when LOGIC_UNIT_FLAGS_EN is defined.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             busy
`ifdef LOGIC_UNIT_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
`endif
);

  logic             s1_vld_q, s1_vld_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s2_adv, in_xfer, out_xfer;
  logic [WIDTH-1:0] res;

  assign s2_adv   = !s2_vld_q || out_ready;
  assign in_ready = !s1_vld_q || s2_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_vld_q && out_ready;

  always_comb begin
    res = '0;
    case (op_q)
      3'b000:  res = a_q & b_q;
      3'b001:  res = a_q | b_q;
      3'b010:  res = a_q ^ b_q;
      3'b011:  res = ~a_q;
      3'b100:  res = ~(a_q & b_q);
      3'b101:  res = ~(a_q | b_q);
      3'b110:  res = ~(a_q ^ b_q);
      default: res = b_q;
    endcase
  end

  always_comb begin
    s1_vld_d = s1_vld_q;
    if (in_xfer)     s1_vld_d = 1'b1;
    else if (s2_adv) s1_vld_d = 1'b0;
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    cnt_d    = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      s2_vld_q <= 1'b0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      cnt_q    <= cnt_d;
      if (in_xfer) begin
        op_q <= in_op;
        a_q  <= in_a;
        b_q  <= in_b;
      end
      // Result only moves with a real beat so out_data stays meaningful between bursts.
      if (s2_adv && s1_vld_q) data_q <= res;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  logic zero_q, ones_q, par_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ones_q <= 1'b0;
      par_q  <= 1'b0;
    end else if (s2_adv && s1_vld_q) begin
      zero_q <= ~|res;
      ones_q <= &res;
      par_q  <= ^res;
    end
  end

  assign out_zero   = zero_q;
  assign out_ones   = ones_q;
  assign out_parity = par_q;
`endif

  assign out_valid = s2_vld_q;
  assign out_data  = data_q;
  assign out_cnt   = cnt_q;
  assign busy      = s1_vld_q || s2_vld_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: randomized and directed beats against a behavioural opcode model.
module tb_logic_unit_pipe;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a, in_b, out_data;
  logic [CNT_W-1:0] out_cnt;
`ifdef LOGIC_UNIT_FLAGS_EN
  logic             out_zero, out_ones, out_parity;
`endif

  logic_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cnt(out_cnt), .busy(busy)
`ifdef LOGIC_UNIT_FLAGS_EN
    , .out_zero(out_zero), .out_ones(out_ones), .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] d;
    int               acc;
  } exp_t;

  exp_t             sb[$];
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;
  int               exp_cnt = 0;
  bit               strict_lat = 0;
  bit               hold_pend = 0;
  logic [WIDTH-1:0] hold_dat;
  bit               rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~a;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every output transfer and checks hold-under-stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(hold_dat));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          if (strict_lat) chk("latency", 32'(cyc - e.acc), 32'd2);
          else            chk("latency_min", 32'(cyc - e.acc >= 2), 32'd1);
          chk("out_cnt_pre", 32'(out_cnt), 32'(exp_cnt % 16));
`ifdef LOGIC_UNIT_FLAGS_EN
          chk("out_zero", 32'(out_zero), 32'(e.d == 0));
          chk("out_ones", 32'(out_ones), 32'(e.d == {WIDTH{1'b1}}));
          chk("out_parity", 32'(out_parity), 32'($countones(e.d) % 2));
`endif
          exp_cnt++;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_dat  = out_data;
    end
  end

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  // Wait for the current beat to be accepted; returns cycles spent stalled.
  task automatic wait_acc(output int waited);
    exp_t e;
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 1000) begin
        chk("accept_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    e.d   = model(in_op, in_a, in_b);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int w;
    drive(op, a, b);
    wait_acc(w);
  endtask

  task automatic wait_idle();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    chk("drain_busy", 32'(busy), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    #7;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1; rst_n = 1'b1;

    // All eight opcodes back to back, a=C5 b=3A.
    strict_lat = 1;
    out_ready  = 1'b1;
    for (int op = 0; op < 8; op++) send(3'(op), 8'hC5, 8'h3A);
    wait_idle();
    strict_lat = 0;
    chk("cnt_after_ops", 32'(out_cnt), 32'd8);

    // Backpressure: two beats fill the pipe, third must stall.
    out_ready = 1'b0;
    send(3'd0, 8'hF0, 8'hFF);
    send(3'd1, 8'h0F, 8'hF0);
    drive(3'd2, 8'hAA, 8'hFF);
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_out_data", 32'(out_data), 32'hF0);
      chk("full_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_acc(w);
    wait_idle();

    // Full pipe with out_ready high: 10 beats must be taken one per cycle.
    out_ready = 1'b0;
    send(3'd6, 8'h12, 8'h34);
    send(3'd7, 8'h56, 8'h78);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
      wait_acc(w);
      chk("stream_no_stall", 32'(w), 32'd0);
    end
    wait_idle();
    chk("cnt_wrap_mod", 32'(out_cnt), 32'(exp_cnt % 16));

    // Random traffic with random backpressure.
    rnd_done = 0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end else begin
            send(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
          end
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(2) != 0);
        end
      end
    join
    wait_idle();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(3'd2, 8'h11, 8'h22);
    send(3'd3, 8'h33, 8'h44);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_cnt", 32'(out_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    exp_cnt = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_out_cnt", 32'(out_cnt), 32'd0);

    // 17 results after reset: counter wraps 15 -> 0 -> 1; first two are the flag vectors.
    send(3'd2, 8'h5A, 8'h5A);
    send(3'd3, 8'h00, 8'h77);
    for (int i = 0; i < 15; i++) send(3'($urandom_range(7)), 8'($urandom), 8'($urandom));
    wait_idle();
    chk("cnt_after_17", 32'(out_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
